// File: rtl/game_seq.sv
// Frame-rate sequencer for the flap/wall game: block physics, wall scroll, gap placement,
// score and the idle/play/dead flow. Geometry only changes on frame_tick so frames stay coherent.
module game_seq #(
    parameter int BlkX       = 200,
    parameter int BlkY0      = 428,
    parameter int WallX0     = 1418,
    parameter int WallSpeed  = 4,
    parameter int Gravity    = 1,
    parameter int FlapV      = 10,
    parameter int MaxFall    = 12,
    parameter int GapInit    = 200,
    parameter int GapMin     = 96,
    parameter int DeadFrames = 60
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    input  logic        btn_start_i,
    input  logic        btn_flap_i,
    input  logic        lose_i,
    output logic [10:0] blkpos_x_o,
    output logic [10:0] blkpos_y_o,
    output logic [10:0] wall_x_o,
    output logic [10:0] gap_y_o,
    output logic [10:0] gap_size_o,
    output logic [7:0]  score_o,
    output logic [1:0]  state_o
);
    localparam int DeadW = $clog2(DeadFrames + 1);

    localparam logic [10:0]        BlkXV      = 11'(BlkX);
    localparam logic [10:0]        BlkY0V     = 11'(BlkY0);
    localparam logic [10:0]        WallX0V    = 11'(WallX0);
    localparam logic [10:0]        WallSpeedV = 11'(WallSpeed);
    localparam logic [10:0]        WallMinV   = 11'(10 + WallSpeed);
    localparam logic [10:0]        GapInitV   = 11'(GapInit);
    localparam logic [10:0]        GapMinV    = 11'(GapMin);
    localparam logic [10:0]        GapY0      = 11'd300;
    localparam logic signed [7:0]  GravV      = 8'(Gravity);
    localparam logic signed [7:0]  NegFlapV   = 8'(-FlapV);
    localparam logic signed [7:0]  MaxFallV   = 8'(MaxFall);
    localparam logic signed [11:0] YMin       = 12'sd10;
    localparam logic signed [11:0] YMax       = 12'sd857;
    localparam logic [DeadW-1:0]   DeadMax    = DeadW'(DeadFrames);
    localparam logic [15:0]        LfsrSeed   = 16'hACE1;
    localparam logic [15:0]        LfsrTaps   = 16'hB400;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StDead = 2'b10
    } state_e;

    state_e            state_q;
    logic [10:0]       blk_y_q, wall_x_q, gap_y_q, gap_size_q;
    logic [7:0]        score_q;
    logic signed [7:0] vel_q;
    logic [15:0]       lfsr_q;
    logic [DeadW-1:0]  dead_cnt_q;
    logic              flap_pend_q, start_prev_q, flap_prev_q;

    logic              start_edge, flap_edge, wall_reload;
    logic signed [7:0] vel_inc, vel_new;
    logic signed [11:0] ny;
    logic [15:0]       lfsr_d;
    logic [10:0]       gap_size_dec;

    always_comb begin
        start_edge   = btn_start_i & ~start_prev_q;
        flap_edge    = btn_flap_i & ~flap_prev_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        vel_inc      = vel_q + GravV;
        if (flap_pend_q) begin
            vel_new = NegFlapV;
        end else if (vel_inc > MaxFallV) begin
            vel_new = MaxFallV;
        end else begin
            vel_new = vel_inc;
        end
        // Signed 12-bit sum so an upward move past the top shows up as a small/negative value.
        ny           = $signed({1'b0, blk_y_q}) + $signed({{4{vel_new[7]}}, vel_new});
        wall_reload  = wall_x_q < WallMinV;
        gap_size_dec = (gap_size_q >= GapMinV + 11'd4) ? gap_size_q - 11'd4 : GapMinV;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            blk_y_q      <= BlkY0V;
            wall_x_q     <= WallX0V;
            gap_y_q      <= GapY0;
            gap_size_q   <= GapInitV;
            score_q      <= 8'd0;
            vel_q        <= '0;
            lfsr_q       <= LfsrSeed;
            dead_cnt_q   <= '0;
            flap_pend_q  <= 1'b0;
            start_prev_q <= 1'b0;
            flap_prev_q  <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            start_prev_q <= btn_start_i;
            flap_prev_q  <= btn_flap_i;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q     <= StPlay;
                        vel_q       <= '0;
                        flap_pend_q <= 1'b0;
                    end
                end
                StPlay: begin
                    if (lose_i) begin
                        // Collision beats a coincident tick: geometry stays as drawn.
                        state_q <= StDead;
                    end else if (frame_tick_i) begin
                        flap_pend_q <= flap_edge;
                        if (ny < YMin) begin
                            blk_y_q <= YMin[10:0];
                            vel_q   <= '0;
                        end else if (ny > YMax) begin
                            blk_y_q <= YMax[10:0];
                            vel_q   <= vel_new;
                            state_q <= StDead;
                        end else begin
                            blk_y_q <= ny[10:0];
                            vel_q   <= vel_new;
                        end
                        if (wall_reload) begin
                            wall_x_q   <= WallX0V;
                            gap_y_q    <= 11'd64 + {2'b00, lfsr_q[8:0]};
                            gap_size_q <= gap_size_dec;
                            if (score_q != 8'hFF) begin
                                score_q <= score_q + 8'd1;
                            end
                        end else begin
                            wall_x_q <= wall_x_q - WallSpeedV;
                        end
                    end else if (flap_edge) begin
                        flap_pend_q <= 1'b1;
                    end
                end
                StDead: begin
                    if (start_edge && dead_cnt_q == DeadMax) begin
                        state_q     <= StIdle;
                        blk_y_q     <= BlkY0V;
                        wall_x_q    <= WallX0V;
                        gap_y_q     <= GapY0;
                        gap_size_q  <= GapInitV;
                        score_q     <= 8'd0;
                        vel_q       <= '0;
                        dead_cnt_q  <= '0;
                        flap_pend_q <= 1'b0;
                    end else if (frame_tick_i && dead_cnt_q != DeadMax) begin
                        dead_cnt_q <= dead_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign blkpos_x_o = BlkXV;
    assign blkpos_y_o = blk_y_q;
    assign wall_x_o   = wall_x_q;
    assign gap_y_o    = gap_y_q;
    assign gap_size_o = gap_size_q;
    assign score_o    = score_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_game_seq.sv
// Directed bench for game_seq: reset, physics, flap merging, wall reload, death/restart flow,
// floor and ceiling clamps.
module tb_game_seq;
    logic        clk, rst_n, frame_tick, btn_start, btn_flap, lose;
    logic [10:0] blkpos_x, blkpos_y, wall_x, gap_y, gap_size;
    logic [7:0]  score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] m_lfsr;
    logic [15:0] tick_lfsr;
    logic [10:0] exp_gap;

    game_seq dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_tick_i (frame_tick),
        .btn_start_i  (btn_start),
        .btn_flap_i   (btn_flap),
        .lose_i       (lose),
        .blkpos_x_o   (blkpos_x),
        .blkpos_y_o   (blkpos_y),
        .wall_x_o     (wall_x),
        .gap_y_o      (gap_y),
        .gap_size_o   (gap_size),
        .score_o      (score),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois LFSR, taps 16,14,13,11, free-running from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic pulse_start();
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
    endtask

    task automatic pulse_flap();
        @(negedge clk); btn_flap = 1'b1;
        @(negedge clk); btn_flap = 1'b0;
    endtask

    task automatic tick(input bit flap);
        if (flap) pulse_flap();
        @(negedge clk); frame_tick = 1'b1; tick_lfsr = m_lfsr;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (blkpos_x !== 11'd200) $display("FAIL reset_x: got %0d want 200", blkpos_x); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd428) $display("FAIL reset_y: got %0d want 428", blkpos_y); else n_pass++;
        n_checks++; if (wall_x !== 11'd1418) $display("FAIL reset_wall: got %0d want 1418", wall_x); else n_pass++;
        n_checks++; if (gap_y !== 11'd300) $display("FAIL reset_gap_y: got %0d want 300", gap_y); else n_pass++;
        n_checks++; if (gap_size !== 11'd200) $display("FAIL reset_gap_size: got %0d want 200", gap_size); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d want 0", score); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_idle();
        tick(1'b1);
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd428) $display("FAIL idle_y: got %0d want 428", blkpos_y); else n_pass++;
        n_checks++; if (wall_x !== 11'd1418) $display("FAIL idle_wall: got %0d want 1418", wall_x); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL idle_state: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_fall();
        pulse_start();
        n_checks++; if (state !== 2'b01) $display("FAIL start_state: got %0d want 1", state); else n_pass++;
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd429) $display("FAIL fall_first_y: got %0d want 429", blkpos_y); else n_pass++;
        for (int i = 0; i < 9; i++) tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd483) $display("FAIL fall_y: got %0d want 483", blkpos_y); else n_pass++;
        n_checks++; if (wall_x !== 11'd1378) $display("FAIL fall_wall: got %0d want 1378", wall_x); else n_pass++;
        pulse_start();
        n_checks++; if (state !== 2'b01) $display("FAIL play_start_ignored: got %0d want 1", state); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd483) $display("FAIL play_start_y: got %0d want 483", blkpos_y); else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_checks++; if (blkpos_y !== 11'd428) $display("FAIL arst_y: got %0d want 428", blkpos_y); else n_pass++;
        n_checks++; if (wall_x !== 11'd1418) $display("FAIL arst_wall: got %0d want 1418", wall_x); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL arst_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (gap_size !== 11'd200) $display("FAIL arst_gap_size: got %0d want 200", gap_size); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_flap();
        pulse_start();
        for (int i = 0; i < 5; i++) tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd443) $display("FAIL flap_pre_y: got %0d want 443", blkpos_y); else n_pass++;
        tick(1'b1);
        n_checks++; if (blkpos_y !== 11'd433) $display("FAIL flap_y: got %0d want 433", blkpos_y); else n_pass++;
        for (int i = 0; i < 3; i++) pulse_flap();
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd423) $display("FAIL flap3_y: got %0d want 423", blkpos_y); else n_pass++;
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd414) $display("FAIL flap_after_y: got %0d want 414", blkpos_y); else n_pass++;
    endtask

    task automatic test_wall_reload();
        do_reset();
        pulse_start();
        // Flapping every 21 frames nets zero drift, keeping the block airborne.
        for (int f = 0; f < 352; f++) tick(f % 21 == 0);
        n_checks++; if (wall_x !== 11'd10) $display("FAIL wall_min: got %0d want 10", wall_x); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd388) $display("FAIL wall_pre_y: got %0d want 388", blkpos_y); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL wall_pre_score: got %0d want 0", score); else n_pass++;
        tick(1'b0);
        exp_gap = 11'd64 + {2'b00, tick_lfsr[8:0]};
        n_checks++; if (wall_x !== 11'd1418) $display("FAIL wall_reload: got %0d want 1418", wall_x); else n_pass++;
        n_checks++; if (score !== 8'd1) $display("FAIL wall_score: got %0d want 1", score); else n_pass++;
        n_checks++; if (gap_size !== 11'd196) $display("FAIL wall_gap_size: got %0d want 196", gap_size); else n_pass++;
        n_checks++; if (gap_y !== exp_gap) $display("FAIL wall_gap_y: got %0d want %0d", gap_y, exp_gap); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd394) $display("FAIL wall_y: got %0d want 394", blkpos_y); else n_pass++;
    endtask

    task automatic test_lose_dead();
        @(negedge clk); lose = 1'b1; frame_tick = 1'b1;
        @(negedge clk); lose = 1'b0; frame_tick = 1'b0;
        n_checks++; if (state !== 2'b10) $display("FAIL lose_state: got %0d want 2", state); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd394) $display("FAIL lose_y: got %0d want 394", blkpos_y); else n_pass++;
        n_checks++; if (wall_x !== 11'd1418) $display("FAIL lose_wall: got %0d want 1418", wall_x); else n_pass++;
        for (int i = 0; i < 30; i++) tick(1'b1);
        pulse_start();
        n_checks++; if (state !== 2'b10) $display("FAIL dead30_state: got %0d want 2", state); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd394) $display("FAIL dead_frozen_y: got %0d want 394", blkpos_y); else n_pass++;
        for (int i = 0; i < 29; i++) tick(1'b0);
        pulse_start();
        n_checks++; if (state !== 2'b10) $display("FAIL dead59_state: got %0d want 2", state); else n_pass++;
        tick(1'b0);
        pulse_start();
        n_checks++; if (state !== 2'b00) $display("FAIL restart_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (blkpos_y !== 11'd428) $display("FAIL restart_y: got %0d want 428", blkpos_y); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL restart_score: got %0d want 0", score); else n_pass++;
        n_checks++; if (gap_size !== 11'd200) $display("FAIL restart_gap_size: got %0d want 200", gap_size); else n_pass++;
        n_checks++; if (gap_y !== 11'd300) $display("FAIL restart_gap_y: got %0d want 300", gap_y); else n_pass++;
    endtask

    task automatic test_floor();
        pulse_start();
        for (int i = 0; i < 41; i++) tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd854) $display("FAIL floor_pre_y: got %0d want 854", blkpos_y); else n_pass++;
        n_checks++; if (state !== 2'b01) $display("FAIL floor_pre_state: got %0d want 1", state); else n_pass++;
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd857) $display("FAIL floor_y: got %0d want 857", blkpos_y); else n_pass++;
        n_checks++; if (state !== 2'b10) $display("FAIL floor_state: got %0d want 2", state); else n_pass++;
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd857) $display("FAIL floor_frozen: got %0d want 857", blkpos_y); else n_pass++;
    endtask

    task automatic test_ceiling();
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        n_checks++; if (blkpos_y !== 11'd352) $display("FAIL ceil_pre_y: got %0d want 352", blkpos_y); else n_pass++;
        for (int i = 0; i < 34; i++) tick(1'b1);
        n_checks++; if (blkpos_y !== 11'd12) $display("FAIL ceil_12: got %0d want 12", blkpos_y); else n_pass++;
        tick(1'b1);
        n_checks++; if (blkpos_y !== 11'd10) $display("FAIL ceil_clamp: got %0d want 10", blkpos_y); else n_pass++;
        tick(1'b0);
        n_checks++; if (blkpos_y !== 11'd11) $display("FAIL ceil_vel0: got %0d want 11", blkpos_y); else n_pass++;
        n_checks++; if (state !== 2'b01) $display("FAIL ceil_state: got %0d want 1", state); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_flap = 1'b0; lose = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_idle();
        test_fall();
        test_reset_mid_play();
        test_flap();
        test_wall_reload();
        test_lose_dead();
        test_floor();
        test_ceiling();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
